uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, payload bits per frame (5..8).
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of 2, >=2).
REQ-003 Parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 bit_clk  input  1  bit-rate square wave from the clock-divider stage; one rising edge per bit period.
REQ-008 tx_data  input  DATA_BITS  word to transmit.
REQ-009 tx_valid  input  1  tx_data valid.
REQ-010 tx_ready  output  1  FIFO can accept a word.
REQ-011 tx  output  1  serial line, idle high, LSB first.
REQ-012 busy  output  1  frame in progress.
REQ-013 fifo_count  output  clog2(FIFO_DEPTH)+1  words currently queued.

Function
REQ-014 bit_clk SHALL pass through a 2-flop synchronizer into a third flop; bit_tick = sync2 & ~sync3, a one-clk pulse.
REQ-015 bit_tick SHALL assert in the 3rd clk cycle after the clk edge that first samples bit_clk high; bit_clk high and low phases are each >=2 clk cycles.
REQ-016 tx_ready SHALL be combinational: fifo_count < FIFO_DEPTH.
REQ-017 A word SHALL be written when tx_valid & tx_ready at a clk edge; tx_valid while not ready SHALL be ignored with no state change.
REQ-018 Push and pop on the same edge SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; state changes SHALL occur only on bit_tick.
REQ-021 IDLE: on bit_tick with fifo_count>0, pop the head word into the shift register, drive tx=0, and go to START; otherwise hold tx=1.
REQ-022 START: on bit_tick, drive bit 0, go to DATA with bit index 0.
REQ-023 DATA: on each bit_tick, drive the next bit LSB first; after DATA_BITS bits, go to PARITY (PARITY_EN=1) or STOP.
REQ-024 PARITY: hold even parity (XOR of the data bits) for one bit period, then go to STOP.
REQ-025 STOP: drive tx=1 for STOP_BITS bit periods; on the tick ending the last stop bit, if fifo_count>0, pop, drive tx=0 and go to START (no idle gap); otherwise go to IDLE.
REQ-026 tx SHALL be driven from a flop; each bit SHALL last exactly one bit_tick interval.
REQ-027 busy SHALL be 1 whenever the state is not IDLE.
REQ-028 FIFO contents SHALL be unaffected by tx_data changes after acceptance.

Reset
REQ-029 While rst=1: tx=1, busy=0, fifo_count=0, tx_ready=1, state=IDLE, synchronizer flops=0, FIFO pointers=0.
REQ-030 rst asserted mid-frame SHALL abort the frame, with tx=1 immediately (asynchronously) and queued words discarded.
REQ-031 After rst deassertion, the first frame SHALL start no earlier than the first bit_tick after a word is queued.

Verification
REQ-032 Defaults, bit_clk period 4 clk, push 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clk, busy high for 40 clk, then tx=1.
REQ-033 bit_clk held low, push 5 words -> tx_ready=0 after the 4th, fifo_count=4, 5th word dropped; enabling bit_clk transmits exactly words 1-4 in order.
REQ-034 Push 0x00 and 0xFF back-to-back -> 20 consecutive bit periods with no idle bit between frames; busy stays 1 throughout.
REQ-035 PARITY_EN=1, push 0x07 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1(stop); PARITY_EN=1 with STOP_BITS=2 adds one more high bit.
REQ-036 Assert rst during data bit 3 -> tx=1 the same cycle, busy=0, fifo_count=0; a new word after release transmits a correct full frame.
REQ-037 Push and pop on the same edge with fifo_count=2 -> fifo_count stays 2 and output order matches input order.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter with a small transmit FIFO. Serialises words
//            LSB first with a start bit, an optional even-parity bit and one
//            or two stop bits. Bit timing comes from an external bit-rate
//            square wave that is synchronised into the clk domain.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_clk,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                 ADDR_W    = $clog2(FIFO_DEPTH);
  localparam int                 CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]         LAST_STOP = 2'(STOP_BITS - 1);
  localparam logic [3:0]         LAST_DATA = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Bit-rate synchroniser: two flops for metastability, a third for edge
  // detection. bit_tick is a single clk-wide pulse per bit_clk rising edge.
  // --------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic sync3;
  logic bit_tick;

  // Synchronise bit_clk and keep a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bit_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign bit_tick = sync2 & ~sync3;

  // --------------------------------------------------------------------------
  // Transmit FIFO. The depth is a power of two, so the pointers wrap simply by
  // overflowing their natural width. The storage array carries no reset; the
  // pointers and count define which entries are meaningful.
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready      = (count < DEPTH_C);
  assign push          = tx_valid & tx_ready;
  assign fifo_nonempty = (count != '0);
  assign head          = mem[rd_ptr];
  assign fifo_count    = count;

  // Capture accepted words; later tx_data changes cannot disturb stored entries
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Advance pointers and track occupancy; simultaneous push/pop keeps count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer. A word is taken from the FIFO either from IDLE or on the
  // tick that ends the final stop bit, which lets consecutive frames run with
  // no idle bit between them.
  // --------------------------------------------------------------------------
  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_bit;
  logic [3:0]           bit_idx;
  logic [1:0]           stop_idx;
  logic                 at_last_stop;

  assign at_last_stop = (state == STOP) && (stop_idx == LAST_STOP);
  assign pop          = bit_tick & fifo_nonempty & ((state == IDLE) | at_last_stop);
  assign busy         = (state != IDLE);

  // Sequence start, data, parity and stop bits; tx is updated only on bit_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      shreg      <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= '0;
    end else if (bit_tick) begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg      <= head;
            parity_bit <= ^head;
            tx         <= 1'b0;
            state      <= START;
          end else begin
            tx <= 1'b1;
          end
        end

        START: begin
          tx      <= shreg[0];
          shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
          bit_idx <= '0;
          state   <= DATA;
        end

        DATA: begin
          // bit_idx names the data bit currently on the line
          if (bit_idx == LAST_DATA) begin
            if (PARITY_EN != 0) begin
              tx    <= parity_bit;
              state <= PARITY;
            end else begin
              tx       <= 1'b1;
              stop_idx <= '0;
              state    <= STOP;
            end
          end else begin
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
          end
        end

        PARITY: begin
          tx       <= 1'b1;
          stop_idx <= '0;
          state    <= STOP;
        end

        STOP: begin
          if (stop_idx == LAST_STOP) begin
            if (pop) begin
              shreg      <= head;
              parity_bit <= ^head;
              tx         <= 1'b0;
              state      <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            tx       <= 1'b1;
            stop_idx <= stop_idx + 2'd1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
